// File: rtl/spike_weight_fetch_if.sv
// -----------------------------------------------------------------------------
// spike_weight_fetch_if
// Bundles the three buses around the weight-fetch controller:
//   spike event in      : spike_valid, spike_src, spike_ready
//   BRAM read port      : bram_re, bram_addrout, bram_dout
//   weight stream out   : w_valid, w_data, w_idx, w_last, w_ready
//   status              : busy, drop
// The master modport is the controller side; the slave modport is everything
// around it (spike source, BRAM, neuron update stage).
// -----------------------------------------------------------------------------
interface spike_weight_fetch_if #(
    parameter int BRAM_WIDTH = 32,
    parameter int BRAM_DEPTH = 256,
    parameter int FANOUT     = 8,
    parameter int SRC_W      = 8
);
    localparam int AW = $clog2(BRAM_DEPTH);
    localparam int IW = $clog2(FANOUT);

    logic                  spike_valid;
    logic [SRC_W-1:0]      spike_src;
    logic                  spike_ready;
    logic                  bram_re;
    logic [AW-1:0]         bram_addrout;
    logic [BRAM_WIDTH-1:0] bram_dout;
    logic                  w_valid;
    logic [BRAM_WIDTH-1:0] w_data;
    logic [IW-1:0]         w_idx;
    logic                  w_last;
    logic                  w_ready;
    logic                  busy;
    logic                  drop;

    modport master (
        input  spike_valid, spike_src, bram_dout, w_ready,
        output spike_ready, bram_re, bram_addrout,
               w_valid, w_data, w_idx, w_last, busy, drop
    );

    modport slave (
        output spike_valid, spike_src, bram_dout, w_ready,
        input  spike_ready, bram_re, bram_addrout,
               w_valid, w_data, w_idx, w_last, busy, drop
    );
endinterface

// File: rtl/spike_weight_fetch.sv
// -----------------------------------------------------------------------------
// spike_weight_fetch
// Read-side controller for the PE's synaptic weight BRAM. Takes one spike
// (source neuron id) at a time, reads that source's FANOUT consecutive weight
// words and streams them to the neuron update stage at up to one word per
// cycle, tagged with the target index and a last flag.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : spike_weight_fetch_if.master (spike in, BRAM read port,
//            weight stream out, busy/drop status)
// -----------------------------------------------------------------------------
module spike_weight_fetch #(
    parameter int BRAM_WIDTH = 32,
    parameter int BRAM_DEPTH = 256,
    parameter int FANOUT     = 8,
    parameter int SRC_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    spike_weight_fetch_if.master bus
);
    localparam int          AW      = $clog2(BRAM_DEPTH);
    localparam int          IW      = $clog2(FANOUT);
    localparam int unsigned NUM_SRC = BRAM_DEPTH / FANOUT;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_STREAM
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [IW-1:0] r_cnt;
    logic [AW-1:0] r_base;
    logic          r_drop;

    logic w_accept;
    logic w_inRange;
    logic w_isLast;
    logic w_advance;

    // Ids at or above BRAM_DEPTH/FANOUT would address past the end of the
    // BRAM, so they are consumed but turned into a drop pulse instead.
    assign w_inRange = 32'(bus.spike_src) < NUM_SRC;
    assign w_accept  = (r_state == S_IDLE) && bus.spike_valid;
    assign w_isLast  = (r_cnt == IW'(FANOUT - 1));
    assign w_advance = (r_state == S_STREAM) && bus.w_ready && !w_isLast;

    // State register. Reset abandons any burst in flight without a last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: one ISSUE cycle primes the BRAM, then STREAM runs until
    // the last word is handed off downstream.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.spike_valid && w_inRange) begin
                    w_nextState = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_nextState = S_STREAM;
            end
            S_STREAM: begin
                if (bus.w_ready && w_isLast) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Burst bookkeeping. The base address is the source id shifted by
    // log2(FANOUT); the counter only moves when downstream takes a word, so a
    // stall leaves index, address and BRAM output all frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_base <= '0;
            r_drop <= 1'b0;
        end else begin
            r_drop <= w_accept && !w_inRange;
            if (w_accept && w_inRange) begin
                r_base <= AW'(bus.spike_src) << IW;
                r_cnt  <= '0;
            end else if (w_advance) begin
                r_cnt <= r_cnt + IW'(1);
            end
        end
    end

    // Outputs. The BRAM has no output register, so the next word's read is
    // issued in the same cycle the current word is accepted; that keeps the
    // stream at one word per cycle while holding re low during stalls keeps
    // bram_dout stable. spike_ready is held low while reset is asserted.
    always_comb begin
        bus.spike_ready  = (r_state == S_IDLE) && rst_n;
        bus.busy         = (r_state != S_IDLE);
        bus.drop         = r_drop;
        bus.bram_re      = 1'b0;
        bus.bram_addrout = '0;
        bus.w_valid      = 1'b0;
        bus.w_data       = '0;
        bus.w_idx        = '0;
        bus.w_last       = 1'b0;
        case (r_state)
            S_ISSUE: begin
                bus.bram_re      = 1'b1;
                bus.bram_addrout = r_base;
            end
            S_STREAM: begin
                bus.w_valid = 1'b1;
                bus.w_data  = bus.bram_dout;
                bus.w_idx   = r_cnt;
                bus.w_last  = w_isLast;
                if (w_advance) begin
                    bus.bram_re      = 1'b1;
                    bus.bram_addrout = r_base + AW'(r_cnt) + AW'(1);
                end
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_spike_weight_fetch.sv
// -----------------------------------------------------------------------------
// tb_spike_weight_fetch
// Directed bench for spike_weight_fetch. A behavioural BRAM (mem[i] = i+0x100,
// registered read on re) sits on the interface; each scenario task drives
// spikes and w_ready and compares against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_spike_weight_fetch;
    localparam int BRAM_WIDTH = 32;
    localparam int BRAM_DEPTH = 256;
    localparam int FANOUT     = 8;
    localparam int SRC_W      = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] mem [0:255];

    logic [31:0] gotData   [0:15];
    logic [2:0]  gotIdx    [0:15];
    logic        gotLast   [0:15];
    int          gotOffset [0:15];
    logic [7:0]  gotAddr   [0:15];
    int          gotCount;
    int          addrCount;
    int          reErr;
    int          stableErr;
    bit          timedOut;

    spike_weight_fetch_if #(
        .BRAM_WIDTH(BRAM_WIDTH), .BRAM_DEPTH(BRAM_DEPTH),
        .FANOUT(FANOUT), .SRC_W(SRC_W)
    ) bus ();

    spike_weight_fetch #(
        .BRAM_WIDTH(BRAM_WIDTH), .BRAM_DEPTH(BRAM_DEPTH),
        .FANOUT(FANOUT), .SRC_W(SRC_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // BRAM read port: address latched on re, data held while re is low.
    always @(posedge clk) begin
        if (bus.bram_re) begin
            bus.bram_dout <= mem[bus.bram_addrout];
        end
    end

    // Hard stop in case something upstream of the bounded loops goes wrong.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Runs one spike (offset 0 = accept window) with w_ready following a
    // repeating 4-cycle pattern, recording handshaken words, read addresses,
    // stall stability violations and reads issued during stalls.
    task automatic collectBurst(input logic [7:0] src, input logic [3:0] pat);
        logic        prevValid;
        logic        prevReady;
        logic [31:0] prevData;
        logic [2:0]  prevIdx;
        logic        prevLast;
        bit          done;
        gotCount  = 0;
        addrCount = 0;
        reErr     = 0;
        stableErr = 0;
        timedOut  = 0;
        prevValid = 0;
        prevReady = 0;
        prevData  = '0;
        prevIdx   = '0;
        prevLast  = 0;
        done      = 0;
        for (int off = 0; off < 64 && !done; off++) begin
            bus.spike_valid = (off == 0);
            bus.spike_src   = src;
            bus.w_ready     = pat[off % 4];
            @(negedge clk);
            if (bus.bram_re && addrCount < 16) begin
                gotAddr[addrCount] = bus.bram_addrout;
                addrCount++;
            end
            if (prevValid && !prevReady &&
                (!bus.w_valid || bus.w_data !== prevData ||
                 bus.w_idx !== prevIdx || bus.w_last !== prevLast)) begin
                stableErr++;
            end
            if (bus.w_valid && !bus.w_ready && bus.bram_re) begin
                reErr++;
            end
            if (bus.w_valid && bus.w_ready && gotCount < 16) begin
                gotData[gotCount]   = bus.w_data;
                gotIdx[gotCount]    = bus.w_idx;
                gotLast[gotCount]   = bus.w_last;
                gotOffset[gotCount] = off;
                gotCount++;
                if (bus.w_last) done = 1;
            end
            prevValid = bus.w_valid;
            prevReady = bus.w_ready;
            prevData  = bus.w_data;
            prevIdx   = bus.w_idx;
            prevLast  = bus.w_last;
            @(posedge clk);
            #1;
        end
        bus.spike_valid = 1'b0;
        bus.w_ready     = 1'b0;
        if (!done) timedOut = 1;
    endtask

    task automatic test_reset();
        bus.spike_valid = 1'b0;
        bus.spike_src   = '0;
        bus.w_ready     = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({bus.busy, bus.w_valid, bus.bram_re, bus.drop, bus.w_last} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl got=%b exp=00000", {bus.busy, bus.w_valid, bus.bram_re, bus.drop, bus.w_last});
        end
        checks++;
        if (bus.bram_addrout !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_addr got=%0d exp=0", bus.bram_addrout);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.spike_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_ready got=%b exp=1", bus.spike_ready);
        end
        checks++;
        if ({bus.busy, bus.w_valid, bus.bram_re, bus.drop} !== 4'b0) begin
            failures++;
            $display("[TB] FAIL post_reset_idle got=%b exp=0000", {bus.busy, bus.w_valid, bus.bram_re, bus.drop});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_stream();
        collectBurst(8'd3, 4'b1111);
        checks++;
        if (timedOut || gotCount != 8) begin
            failures++;
            $display("[TB] FAIL basic_count got=%0d exp=8 timeout=%0d", gotCount, timedOut);
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (gotData[j] !== 32'h118 + 32'(j) || gotIdx[j] !== 3'(j) ||
                gotLast[j] !== (j == 7) || gotOffset[j] != 2 + j) begin
                failures++;
                $display("[TB] FAIL basic_word[%0d] got data=%h idx=%0d last=%b off=%0d exp data=%h idx=%0d last=%b off=%0d",
                         j, gotData[j], gotIdx[j], gotLast[j], gotOffset[j], 32'h118 + 32'(j), j, (j == 7), 2 + j);
            end
        end
        checks++;
        if (addrCount != 8 || gotAddr[0] !== 8'd24 || gotAddr[7] !== 8'd31) begin
            failures++;
            $display("[TB] FAIL basic_addr got count=%0d first=%0d last=%0d exp count=8 first=24 last=31",
                     addrCount, gotAddr[0], gotAddr[7]);
        end
    endtask

    task automatic test_stall();
        collectBurst(8'd5, 4'b1001);
        checks++;
        if (timedOut || gotCount != 8) begin
            failures++;
            $display("[TB] FAIL stall_count got=%0d exp=8 timeout=%0d", gotCount, timedOut);
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (gotData[j] !== 32'h128 + 32'(j) || gotIdx[j] !== 3'(j) || gotLast[j] !== (j == 7)) begin
                failures++;
                $display("[TB] FAIL stall_word[%0d] got data=%h idx=%0d last=%b exp data=%h idx=%0d last=%b",
                         j, gotData[j], gotIdx[j], gotLast[j], 32'h128 + 32'(j), j, (j == 7));
            end
        end
        checks++;
        if (stableErr != 0) begin
            failures++;
            $display("[TB] FAIL stall_hold got=%0d exp=0 unstable cycles", stableErr);
        end
        checks++;
        if (reErr != 0) begin
            failures++;
            $display("[TB] FAIL stall_re got=%0d exp=0 reads during stall", reErr);
        end
        checks++;
        if (gotOffset[7] != 16) begin
            failures++;
            $display("[TB] FAIL stall_last_offset got=%0d exp=16", gotOffset[7]);
        end
        checks++;
        if (addrCount != 8 || gotAddr[0] !== 8'd40 || gotAddr[7] !== 8'd47) begin
            failures++;
            $display("[TB] FAIL stall_addr got count=%0d first=%0d last=%0d exp count=8 first=40 last=47",
                     addrCount, gotAddr[0], gotAddr[7]);
        end
    endtask

    task automatic test_drop();
        int reSeen;
        int validSeen;
        int busySeen;
        reSeen    = 0;
        validSeen = 0;
        busySeen  = 0;
        for (int w = 0; w < 5; w++) begin
            bus.spike_valid = (w == 0);
            bus.spike_src   = 8'd32;
            bus.w_ready     = 1'b1;
            @(negedge clk);
            if (bus.bram_re) reSeen++;
            if (bus.w_valid) validSeen++;
            if (bus.busy) busySeen++;
            if (w == 1) begin
                checks++;
                if (bus.drop !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL drop_pulse got=%b exp=1", bus.drop);
                end
            end
            if (w == 2) begin
                checks++;
                if (bus.drop !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL drop_width got=%b exp=0", bus.drop);
                end
            end
            @(posedge clk);
            #1;
        end
        bus.spike_valid = 1'b0;
        bus.w_ready     = 1'b0;
        checks++;
        if (reSeen != 0 || validSeen != 0 || busySeen != 0) begin
            failures++;
            $display("[TB] FAIL drop_quiet got re=%0d valid=%0d busy=%0d exp all 0", reSeen, validSeen, busySeen);
        end
    endtask

    task automatic test_top_source();
        collectBurst(8'd31, 4'b1111);
        checks++;
        if (timedOut || gotCount != 8) begin
            failures++;
            $display("[TB] FAIL top_count got=%0d exp=8 timeout=%0d", gotCount, timedOut);
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (gotData[j] !== 32'h1F8 + 32'(j) || gotAddr[j] !== 8'(248 + j)) begin
                failures++;
                $display("[TB] FAIL top_word[%0d] got data=%h addr=%0d exp data=%h addr=%0d",
                         j, gotData[j], gotAddr[j], 32'h1F8 + 32'(j), 248 + j);
            end
        end
        checks++;
        if (gotLast[7] !== 1'b1 || gotData[7] !== 32'h1FF) begin
            failures++;
            $display("[TB] FAIL top_last got last=%b data=%h exp last=1 data=000001ff", gotLast[7], gotData[7]);
        end
    endtask

    task automatic test_back_to_back();
        int          accepts;
        int          words;
        int          acceptWin [0:1];
        int          lastWin;
        logic [31:0] data [0:15];
        logic        last [0:15];
        bit          acceptNow;
        accepts      = 0;
        words        = 0;
        lastWin      = -1;
        acceptWin[0] = -1;
        acceptWin[1] = -1;
        for (int w = 0; w < 64 && words < 16; w++) begin
            bus.spike_valid = (accepts < 2);
            bus.spike_src   = (accepts == 0) ? 8'd1 : 8'd2;
            bus.w_ready     = 1'b1;
            acceptNow       = 0;
            @(negedge clk);
            if (bus.spike_valid && bus.spike_ready) begin
                acceptWin[accepts] = w;
                acceptNow = 1;
            end
            if (bus.w_valid && bus.w_ready) begin
                data[words] = bus.w_data;
                last[words] = bus.w_last;
                if (bus.w_last && lastWin < 0) lastWin = w;
                words++;
            end
            @(posedge clk);
            #1;
            if (acceptNow) accepts++;
        end
        bus.spike_valid = 1'b0;
        bus.w_ready     = 1'b0;
        checks++;
        if (words != 16) begin
            failures++;
            $display("[TB] FAIL b2b_count got=%0d exp=16", words);
        end
        checks++;
        if (acceptWin[0] != 0 || lastWin != 9 || acceptWin[1] != 10) begin
            failures++;
            $display("[TB] FAIL b2b_spacing got acc0=%0d last=%0d acc1=%0d exp acc0=0 last=9 acc1=10",
                     acceptWin[0], lastWin, acceptWin[1]);
        end
        for (int j = 0; j < 16 && j < words; j++) begin
            checks++;
            if (data[j] !== 32'h108 + 32'(j) || last[j] !== (j % 8 == 7)) begin
                failures++;
                $display("[TB] FAIL b2b_word[%0d] got data=%h last=%b exp data=%h last=%b",
                         j, data[j], last[j], 32'h108 + 32'(j), (j % 8 == 7));
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        bit found;
        found = 0;
        for (int w = 0; w < 20 && !found; w++) begin
            bus.spike_valid = (w == 0);
            bus.spike_src   = 8'd6;
            bus.w_ready     = 1'b1;
            @(negedge clk);
            if (bus.w_valid && bus.w_idx == 3'd4) begin
                found = 1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        bus.spike_valid = 1'b0;
        checks++;
        if (!found || bus.w_data !== 32'h134) begin
            failures++;
            $display("[TB] FAIL midrst_reach got found=%0d data=%h exp found=1 data=00000134", found, bus.w_data);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.w_valid, bus.busy, bus.bram_re, bus.w_last, bus.drop} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL midrst_ctrl got=%b exp=00000", {bus.w_valid, bus.busy, bus.bram_re, bus.w_last, bus.drop});
        end
        checks++;
        if (bus.w_data !== 32'h0 || bus.w_idx !== 3'd0 || bus.bram_addrout !== 8'd0) begin
            failures++;
            $display("[TB] FAIL midrst_data got data=%h idx=%0d addr=%0d exp 0 0 0", bus.w_data, bus.w_idx, bus.bram_addrout);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        collectBurst(8'd0, 4'b1111);
        checks++;
        if (timedOut || gotCount != 8) begin
            failures++;
            $display("[TB] FAIL midrst_count got=%0d exp=8 timeout=%0d", gotCount, timedOut);
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (gotData[j] !== 32'h100 + 32'(j) || gotIdx[j] !== 3'(j) ||
                gotLast[j] !== (j == 7) || gotOffset[j] != 2 + j) begin
                failures++;
                $display("[TB] FAIL midrst_word[%0d] got data=%h idx=%0d last=%b off=%0d exp data=%h idx=%0d last=%b off=%0d",
                         j, gotData[j], gotIdx[j], gotLast[j], gotOffset[j], 32'h100 + 32'(j), j, (j == 7), 2 + j);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h100 + 32'(i);
        end
        test_reset();
        test_basic_stream();
        test_stall();
        test_drop();
        test_top_source();
        test_back_to_back();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
